// File: rtl/rv32i_seq_ctrl.sv
// Multi-cycle fetch/decode/execute/mem/writeback sequencer for the rv32i core.
// Optional trapping on illegal opcodes / misaligned targets: RV32I_TRAP_ILLEGAL_EN.
module rv32i_seq_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] ir,
    input  logic [31:0] imm,
    input  logic [31:0] alu_result,
    input  logic        branch_taken,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    input  logic        dmem_ack,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic [31:0] pc,
    output logic        instret,
    output logic        trap
);
    typedef enum logic [2:0] {
        FETCH, DECODE, EXECUTE, MEM, WRITEBACK, TRAP
    } state_t;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    state_t      state, state_nxt;
    logic [31:0] next_pc;
    logic [31:0] npc_calc;
    logic [6:0]  opcode;
    logic        is_load, is_store, is_jal, is_jalr, is_branch, writes_rd;

    assign opcode    = ir[6:0];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_jal    = (opcode == OP_JAL);
    assign is_jalr   = (opcode == OP_JALR);
    assign is_branch = (opcode == OP_BRANCH);
    assign writes_rd = (opcode == OP_LUI) || (opcode == OP_AUIPC) || is_jal || is_jalr ||
                       (opcode == OP_IMM) || (opcode == OP_OP) || is_load;

    always_comb begin
        npc_calc = pc + 32'd4;
        if (is_jal)
            npc_calc = pc + imm;
        else if (is_jalr)
            npc_calc = alu_result & ~32'h1;
        else if (is_branch && branch_taken)
            npc_calc = pc + imm;
    end

`ifdef RV32I_TRAP_ILLEGAL_EN
    logic is_legal, misaligned;
    assign is_legal   = writes_rd || is_branch || is_store ||
                        (opcode == 7'b0001111) || (opcode == 7'b1110011);
    assign misaligned = (is_jal || is_jalr || (is_branch && branch_taken)) && npc_calc[1];
    assign trap       = (state == TRAP);
`else
    assign trap = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            ir        <= '0;
            dmem_addr <= '0;
            next_pc   <= '0;
        end else begin
            state <= state_nxt;
            if (state == FETCH && imem_ack)
                ir <= imem_rdata;
            if (state == EXECUTE) begin
                dmem_addr <= alu_result;
                next_pc   <= npc_calc;
            end
            if (state == WRITEBACK)
                pc <= next_pc;
        end
    end

    // Every strobe is masked by rst so an outstanding request drops in the reset cycle.
    always_comb begin
        state_nxt = state;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        reg_we    = 1'b0;
        instret   = 1'b0;
        case (state)
            FETCH: begin
                imem_req = !rst;
                if (imem_ack)
                    state_nxt = DECODE;
            end
            DECODE:
                state_nxt = EXECUTE;
            EXECUTE: begin
                if (is_load || is_store)
                    state_nxt = MEM;
                else
                    state_nxt = WRITEBACK;
`ifdef RV32I_TRAP_ILLEGAL_EN
                if (!is_legal || misaligned)
                    state_nxt = TRAP;
`endif
            end
            MEM: begin
                dmem_req = !rst;
                dmem_we  = !rst && is_store;
                if (dmem_ack)
                    state_nxt = WRITEBACK;
            end
            WRITEBACK: begin
                reg_we    = !rst && writes_rd && (ir[11:7] != 5'd0);
                instret   = !rst;
                state_nxt = FETCH;
            end
            TRAP:
                state_nxt = TRAP;
            default:
                state_nxt = FETCH;
        endcase
    end

    always_comb begin
        wb_sel = 2'd0;
        if (is_load)
            wb_sel = 2'd1;
        else if (is_jal || is_jalr)
            wb_sel = 2'd2;
    end

    assign imem_addr = pc;

endmodule
